// File: rtl/serial_pkg.sv
// Shared definitions for the serial block: receiver FSM states, default
// line timing, register map offsets and status bit positions.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HI
    } rx_state_t;

    localparam int unsigned DEF_CLK_FREQ = 50000000;
    localparam int unsigned DEF_BAUD     = 115200;

    localparam logic [3:0] REG_DATA   = 4'h8;
    localparam logic [3:0] REG_STATUS = 4'hc;

    localparam int unsigned STAT_CAN_WRITE = 0;
    localparam int unsigned STAT_CAN_READ  = 1;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side bus between the receive FIFO and the serial register stage.
// slave: the receiver/FIFO side; master: the register stage side.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH = 16
) ();
    logic                     pop;
    logic                     clr_err;
    logic [7:0]               data;
    logic                     valid;
    logic [$clog2(DEPTH):0]   count;
    logic                     overrun;
    logic                     frame_err;
    logic                     parity_err;

    modport slave (
        input  pop,
        input  clr_err,
        output data,
        output valid,
        output count,
        output overrun,
        output frame_err,
        output parity_err
    );

    modport master (
        output pop,
        output clr_err,
        input  data,
        input  valid,
        input  count,
        input  overrun,
        input  frame_err,
        input  parity_err
    );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. A push while full is accepted only when a
// pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers (wrapping modulo DEPTH) and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) feeding a byte FIFO, with sticky
// overrun / framing / parity error flags.
// Build option: define UART_RX_PARITY_EN for an even-parity bit (8E1).
module uart_rx_fifo
    import serial_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD,
    parameter int unsigned DEPTH    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rxd,
    uart_rx_fifo_if.slave  bus
);
    localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;
    localparam int unsigned HALF    = BIT_CYC / 2;
    localparam int unsigned DIV_W   = $clog2(BIT_CYC) + 1;
    localparam logic [DIV_W-1:0] BIT_LIM  = DIV_W'(BIT_CYC - 1);
    localparam logic [DIV_W-1:0] HALF_LIM = DIV_W'(HALF - 1);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             rx_meta;
    logic             rx_s;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_lim;
    logic             tick;
    logic [2:0]       idx;
    logic [7:0]       sr;
    logic             sample_dat;
    logic             stop_ok;
    logic             set_fe;
    logic             push;
    logic             ovf_set;
    logic             fifo_full;
    logic             fifo_empty;
    logic             overrun_q;
    logic             frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic             set_pe;
    logic             par_bad;
    logic             parity_err_q;
`endif

    // Two-flop synchronizer for the asynchronous line (idles high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    assign div_lim = (state == START) ? HALF_LIM : BIT_LIM;
    assign tick    = (div == div_lim);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_s) state_nxt = START;
            START:   if (tick) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:    if (tick && idx == 3'd7) state_nxt = PARITY;
            PARITY:  if (tick) state_nxt = STOP;
`else
            DATA:    if (tick && idx == 3'd7) state_nxt = STOP;
`endif
            STOP:    if (tick) state_nxt = rx_s ? IDLE : WAIT_HI;
            WAIT_HI: if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: sample strobes and error/push events
    always_comb begin
        sample_dat = 1'b0;
        stop_ok    = 1'b0;
        set_fe     = 1'b0;
`ifdef UART_RX_PARITY_EN
        set_pe     = 1'b0;
`endif
        case (state)
            DATA:    sample_dat = tick;
`ifdef UART_RX_PARITY_EN
            PARITY:  set_pe = tick && (^{sr, rx_s});
`endif
            STOP: begin
                stop_ok = tick && rx_s;
                set_fe  = tick && !rx_s;
            end
            default: ;
        endcase
    end

    // Bit-period divider; reloads on every state change and every sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (state_nxt != state || tick || state == IDLE || state == WAIT_HI) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Shift register and bit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            sr  <= '0;
        end else if (state == START) begin
            idx <= '0;
        end else if (sample_dat) begin
            sr[idx] <= rx_s;
            idx     <= idx + 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    // A bad parity bit marks the frame so the stop sample drops the byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              par_bad <= 1'b0;
        else if (state == START) par_bad <= 1'b0;
        else if (set_pe)         par_bad <= 1'b1;
    end

    assign push = stop_ok && !par_bad;
`else
    assign push = stop_ok;
`endif

    assign ovf_set = push && fifo_full && !bus.pop;

    // Sticky error flags; a new error outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (ovf_set)          overrun_q <= 1'b1;
            else if (bus.clr_err) overrun_q <= 1'b0;
            if (set_fe)           frame_err_q <= 1'b1;
            else if (bus.clr_err) frame_err_q <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           parity_err_q <= 1'b0;
        else if (set_pe)      parity_err_q <= 1'b1;
        else if (bus.clr_err) parity_err_q <= 1'b0;
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
    assign bus.valid     = !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (bus.pop),
        .din   (sr),
        .dout  (bus.data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (bus.count)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard.
// Configuration: CLK_FREQ=16, BAUD=1 (16 clocks per bit), DEPTH=4.
module tb_uart_rx_fifo;
    import serial_pkg::*;

    localparam int unsigned CF = 16;
    localparam int unsigned BD = 1;
    localparam int unsigned DP = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd   = 1'b1;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(DP)) bus ();

    uart_rx_fifo #(
        .CLK_FREQ (CF),
        .BAUD     (BD),
        .DEPTH    (DP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .bus   (bus)
    );

    int         checks  = 0;
    int         errors  = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovr = 1'b0;
    logic       exp_fe  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: plain frame; 1: check push latency; 2: pop on the push edge;
    // 3: clr_err on the stop-sample edge
    task automatic send(input logic [7:0] b, input logic stop, input int mode);
        rxd = 1'b0;
        cyc(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cyc(16);
        end
        rxd = stop;
        cyc(10);
        if (mode == 1) chk("valid_before_push", {31'd0, bus.valid}, 32'd0);
        if (mode == 2) begin
            if (exp_q.size() > 0) chk("head_at_push", {24'd0, bus.data}, {24'd0, exp_q[0]});
            bus.pop = 1'b1;
        end
        if (mode == 3) bus.clr_err = 1'b1;
        cyc(1);
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;
        if (mode == 1) chk("valid_after_push", {31'd0, bus.valid}, 32'd1);
        if (mode == 2 && exp_q.size() > 0) void'(exp_q.pop_front());
        cyc(5);
        if (stop) begin
            if (exp_q.size() < DP) exp_q.push_back(b);
            else                   exp_ovr = 1'b1;
        end else begin
            exp_fe = 1'b1;
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_empty"}, {31'd0, bus.valid}, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, {31'd0, bus.valid}, 32'd1);
            chk({tag, "_data"}, {24'd0, bus.data}, {24'd0, e});
            bus.pop = 1'b1;
            cyc(1);
            bus.pop = 1'b0;
            chk({tag, "_count"}, 32'(bus.count), 32'(exp_q.size()));
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_count"},   32'(bus.count), 32'(exp_q.size()));
        chk({tag, "_overrun"}, {31'd0, bus.overrun}, {31'd0, exp_ovr});
        chk({tag, "_frame"},   {31'd0, bus.frame_err}, {31'd0, exp_fe});
        chk({tag, "_parity"},  {31'd0, bus.parity_err}, 32'd0);
    endtask

    logic [7:0] seq_bytes [6] = '{8'h47, 8'h00, 8'h20, 8'h00, 8'h80, 8'h52};

    initial begin
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;

        // Reset state
        cyc(3);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_data", {24'd0, bus.data}, 32'd0);
        chk_status("rst");
        rst_n = 1'b1;
        cyc(5);

        // Single byte with push latency
        send(8'h47, 1'b1, 1);
        chk("single_data", {24'd0, bus.data}, 32'h47);
        chk("single_count", 32'(bus.count), 32'd1);
        pop_chk("single_pop");
        chk("single_valid_after_pop", {31'd0, bus.valid}, 32'd0);

        // Pop while empty has no effect
        bus.pop = 1'b1;
        cyc(1);
        bus.pop = 1'b0;
        chk("empty_pop_count", 32'(bus.count), 32'd0);

        // Push and pop on the same edge while empty: pop ignored
        send(8'h11, 1'b1, 2);
        chk("empty_pushpop_count", 32'(bus.count), 32'd1);
        pop_chk("empty_pushpop");

        // Sequence with pop after each byte
        foreach (seq_bytes[i]) begin
            send(seq_bytes[i], 1'b1, 0);
            pop_chk("seq");
        end
        chk_status("seq");

        // Overrun
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 0);
        chk_status("ovr");
        for (int i = 0; i < 4; i++) pop_chk("ovr_pop");
        bus.clr_err = 1'b1;
        cyc(1);
        bus.clr_err = 1'b0;
        exp_ovr = 1'b0;
        chk_status("ovr_clr");

        // Framing error, with a clear on the same edge (the set must win)
        send(8'h55, 1'b0, 3);
        cyc(40);
        chk_status("frame");
        rxd = 1'b1;
        cyc(16);
        send(8'hAA, 1'b1, 0);
        pop_chk("after_frame");
        bus.clr_err = 1'b1;
        cyc(1);
        bus.clr_err = 1'b0;
        exp_fe = 1'b0;
        chk_status("frame_clr");

        // Short glitch is rejected
        rxd = 1'b0;
        cyc(4);
        rxd = 1'b1;
        cyc(20);
        chk("glitch_state", 32'(dut.state), 32'(IDLE));
        chk_status("glitch");

        // Reset mid-frame
        send(8'h5A, 1'b1, 0);
        chk("pre_rst_data", {24'd0, bus.data}, 32'h5A);
        rxd = 1'b0;
        cyc(16);
        rxd = 1'b1;
        cyc(16);
        rxd = 1'b0;
        cyc(20);
        rst_n = 1'b0;
        rxd   = 1'b1;
        cyc(2);
        exp_q.delete();
        chk("midrst_valid", {31'd0, bus.valid}, 32'd0);
        chk("midrst_data", {24'd0, bus.data}, 32'd0);
        chk_status("midrst");
        rst_n = 1'b1;
        cyc(16);
        send(8'h3C, 1'b1, 0);
        pop_chk("post_rst");

        // Full FIFO with push and pop on the same edge
        for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1'b1, 0);
        send(8'hA4, 1'b1, 2);
        chk_status("full_pushpop");
        for (int i = 0; i < 4; i++) pop_chk("full_pushpop_pop");

        // Streaming run across pointer wrap
        for (int i = 0; i < 10; i++) begin
            send(8'hC3 + 8'(i * 29), 1'b1, 0);
            if (exp_q.size() >= 3) pop_chk("stream");
        end
        while (exp_q.size() > 0) pop_chk("stream_drain");
        chk_status("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver (8N1, LSB first) with a byte FIFO.
- Feeds the serial register stage. That stage reads the head byte on a data-register load, pops on that read, and builds `can_read` in its status register from `valid`.
- Replaces hard-coded input bytes with real bytes received on the `rxd` pin.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz.
- BAUD, 115200, line rate in bits per second.
- DEPTH, 16, number of FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- rxd  input  1  asynchronous serial line; idles high.
- pop  input  1  consume head byte this cycle; ignored when `valid`=0.
- data  output  8  head byte (show-ahead); holds stale contents when empty.
- valid  output  1  FIFO not empty.
- count  output  $clog2(DEPTH)+1  number of bytes held.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: a stop bit was sampled as 0.
- parity_err  output  1  sticky: parity mismatch.
- clr_err  input  1  clears all three sticky flags.

Behaviour:
- Reset values: `valid`=0, `count`=0, `data`=0, all flags 0, FSM=IDLE, sync flops=1, pointers=0.
- Reset mid-frame: the partial byte is discarded.
- Sampling timing:
  - BIT_CYC = CLK_FREQ/BAUD, using integer division.
  - HALF = BIT_CYC/2.
  - `rxd` passes through a 2-flop synchronizer; the logic uses the synchronized signal `rx_s`.
- FSM:
  - IDLE: `rx_s`=0 → START, clear the divider.
  - START: after HALF cycles, sample `rx_s`. If 1 → IDLE (glitch rejected). If 0 → DATA, bit index 0.
  - DATA: every BIT_CYC cycles, sample into shift register `sr[idx]`. After idx 7 → STOP (or PARITY when the option is compiled in).
  - STOP: after BIT_CYC, sample.
    - 1 → push `sr` and go to IDLE.
    - 0 → set `frame_err`, drop the byte, go to WAIT_HI.
  - WAIT_HI: stay until `rx_s`=1, then IDLE. A break condition never loops.
- Latency:
  - Push occurs on the clock edge where the stop bit is sampled.
  - `valid`, `data`, and `count` reflect the push on the following cycle.
- FIFO:
  - Storage is registered; `data` = `mem[rd_ptr]`.
  - `pop` with `valid`=1 advances `rd_ptr` at the edge.
  - Pointers wrap modulo DEPTH.
- Boundary conditions:
  - Push while full and no pop: byte dropped, `overrun` set, contents unchanged.
  - Push and pop in the same cycle while full: both accepted; `count` unchanged.
  - Push and pop in the same cycle while empty: push accepted, pop ignored; `count` becomes 1.
  - Pop while empty: no effect.
  - `clr_err` in the same cycle as a new error: the set wins.
- Divider arithmetic: counter width $clog2(BIT_CYC)+1. It reloads on every state transition.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one bit after BIT_CYC cycles.
  - Parity is even: the XOR of 8 data bits plus the parity bit must be 0.
  - On mismatch, `parity_err` is set and the byte is dropped. The STOP state is still traversed and frame checking still applies.
- Undefined: 8N1 only; `parity_err` is tied to 0; frame length is 10 bits.

Decomposition:
- Shared package `serial_pkg`:
  - rx FSM state enum: IDLE, START, DATA, PARITY, STOP, WAIT_HI.
  - Default CLK_FREQ/BAUD constants.
  - Register offsets: data 0x8, status 0xc.
  - Status bit positions: bit0 can_write, bit1 can_read.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; ports push/pop/din/dout/full/empty/count).
- The receiver FSM and flag logic stay in the top module.

Test Plan:
- All scenarios use CLK_FREQ=16, BAUD=1, DEPTH=4, so BIT_CYC=16.
- Single byte: send 0x47 ('G') as a frame → `valid` rises 1 cycle after the stop sample, `data`=0x47, `count`=1; `pop` → `valid`=0, `count`=0.
- Sequence: send "G",0x00,0x20,0x00,0x80,"R", popping after each → read-back bytes match in order; no flags set.
- Overrun: send 5 bytes 0x01..0x05 without pop → `count`=4, `overrun`=1, pops return 0x01..0x04; `clr_err` → `overrun`=0.
- Framing: send 0x55 with stop=0, holding the line low for 40 cycles → `frame_err`=1, `count`=0; then a valid 0xAA → received correctly.
- Glitch and reset:
  - 4-cycle low pulse on `rxd` → no start detected, FSM returns to IDLE.
  - Assert `rst_n`=0 mid-byte → all outputs return to reset values; the next full frame 0x3C is received intact.
- Wrap and simultaneous push/pop:
  - Fill to 4, then pop on the exact cycle of a push → `count` stays 4, no `overrun`.
  - 10-byte streaming run exercises pointer wrap with correct data order.
